// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the L1 cache port arbiter.
// State/owner encodings and the arbitration decision.
package cache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_D = 1'b0,
    ARB_OWNER_I = 1'b1
  } arb_owner_e;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic HOLD_ENABLE  = 1'b1;

  localparam int BURST_W = 4;
  localparam int WDOG_W  = 8;

  // Data wins unless fetch is waiting and the burst budget is spent.
  function automatic arb_state_e arb_pick(
    input logic d_req,
    input logic i_req,
    input logic burst_full
  );
    arb_state_e s;
    s = ARB_IDLE;
    if (d_req && !(i_req && burst_full)) begin
      s = ARB_BUSY_D;
    end else if (i_req) begin
      s = ARB_BUSY_I;
    end
    return s;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Single read/write port of the L1 cache.
// master = arbiter side, slave = cache side.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_re_o;
  logic [ADDR_W-1:0] c_raddr_o;
  logic              c_rhit_i;
  logic [DATA_W-1:0] c_rdata_i;
  logic              c_we_o;
  logic [ADDR_W-1:0] c_waddr_o;
  logic [DATA_W-1:0] c_wdata_o;
  logic              c_whit_i;

  modport master (
    output c_re_o,
    output c_raddr_o,
    input  c_rhit_i,
    input  c_rdata_i,
    output c_we_o,
    output c_waddr_o,
    output c_wdata_o,
    input  c_whit_i
  );

  modport slave (
    input  c_re_o,
    input  c_raddr_o,
    output c_rhit_i,
    output c_rdata_i,
    input  c_we_o,
    input  c_waddr_o,
    input  c_wdata_o,
    output c_whit_i
  );
endinterface

// File: rtl/cache_port_arbiter_watchdog.sv
// Busy-cycle watchdog: expires on the TIMEOUT-th
// enabled cycle after a clear.
module arb_watchdog
  import cache_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] LAST =
    WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates the L1 cache port between fetch and load/store,
// with burst-limited data priority and a hit watchdog.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_done_o,
  output logic [DATA_W-1:0] i_rdata_o,
  cache_port_arbiter_if.master cache,
  output logic              hold_flag_o,
  output logic              err_o
);

  localparam logic [BURST_W-1:0] BURST_MAX =
    BURST_W'(MAX_DATA_BURST);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic              we_q;
  logic [BURST_W-1:0] burst_q;
  logic              d_gnt_q;
  logic              i_gnt_q;
  logic              d_done_q;
  logic              i_done_q;
  logic              err_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;

  arb_state_e pick;
  logic       busy;
  logic       hit;
  logic       expired;

  assign pick = arb_pick(d_req_i, i_req_i,
                         burst_q >= BURST_MAX);
  assign busy = (state_q == ARB_BUSY_D) ||
                (state_q == ARB_BUSY_I);
  assign hit  = we_q ? cache.c_whit_i
                     : cache.c_rhit_i;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (!busy),
    .en_i     (busy && !hit),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ARB_IDLE;
      owner_q         <= ARB_OWNER_D;
      we_q            <= 1'b0;
      burst_q         <= '0;
      d_gnt_q         <= 1'b0;
      i_gnt_q         <= 1'b0;
      d_done_q        <= 1'b0;
      i_done_q        <= 1'b0;
      err_q           <= 1'b0;
      d_rdata_q       <= '0;
      i_rdata_q       <= '0;
      cache.c_re_o    <= READ_DISABLE;
      cache.c_raddr_o <= '0;
      cache.c_we_o    <= 1'b0;
      cache.c_waddr_o <= '0;
      cache.c_wdata_o <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick == ARB_BUSY_D) begin
            state_q <= ARB_BUSY_D;
            owner_q <= ARB_OWNER_D;
            d_gnt_q <= 1'b1;
            we_q    <= d_we_i;
            if (d_we_i) begin
              cache.c_we_o    <= 1'b1;
              cache.c_waddr_o <= d_addr_i;
              cache.c_wdata_o <= d_wdata_i;
            end else begin
              cache.c_re_o    <= READ_ENABLE;
              cache.c_raddr_o <= d_addr_i;
            end
            if (!i_req_i) begin
              burst_q <= '0;
            end else if (burst_q < BURST_MAX) begin
              burst_q <= burst_q + BURST_W'(1);
            end
          end else if (pick == ARB_BUSY_I) begin
            state_q         <= ARB_BUSY_I;
            owner_q         <= ARB_OWNER_I;
            i_gnt_q         <= 1'b1;
            we_q            <= 1'b0;
            burst_q         <= '0;
            cache.c_re_o    <= READ_ENABLE;
            cache.c_raddr_o <= i_addr_i;
          end
        end
        ARB_BUSY_D,
        ARB_BUSY_I: begin
          if (hit || expired) begin
            state_q         <= ARB_DONE;
            d_gnt_q         <= 1'b0;
            i_gnt_q         <= 1'b0;
            cache.c_re_o    <= READ_DISABLE;
            cache.c_raddr_o <= '0;
            cache.c_we_o    <= 1'b0;
            cache.c_waddr_o <= '0;
            cache.c_wdata_o <= '0;
            err_q           <= !hit;
            // A hit on the expiry cycle is a normal completion.
            if (owner_q == ARB_OWNER_D) begin
              d_done_q <= 1'b1;
              if (!hit) begin
                d_rdata_q <= '0;
              end else if (!we_q) begin
                d_rdata_q <= cache.c_rdata_i;
              end
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= hit ? cache.c_rdata_i : '0;
            end
          end
        end
        ARB_DONE: begin
          state_q  <= ARB_IDLE;
          d_done_q <= 1'b0;
          i_done_q <= 1'b0;
          err_q    <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign d_gnt_o   = d_gnt_q;
  assign i_gnt_o   = i_gnt_q;
  assign d_done_o  = d_done_q;
  assign i_done_o  = i_done_q;
  assign d_rdata_o = d_rdata_q;
  assign i_rdata_o = i_rdata_q;
  assign err_o     = err_q;

  // Gated by reset so the stall drops as soon as reset asserts.
  assign hold_flag_o = rst && i_req_i &&
    !((state_q == ARB_DONE) && (owner_q == ARB_OWNER_I));

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter
// (MAX_DATA_BURST=4, TIMEOUT=8).
module tb_cache_port_arbiter;

  logic        clk;
  logic        rst;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_done;
  logic [31:0] i_rdata;
  logic        hold_flag, err;

  int n_cmp = 0;
  int n_bad = 0;

  cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cif ();

  cache_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MAX_DATA_BURST(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .d_req_i(d_req), .d_we_i(d_we),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_done_o(d_done),
    .d_rdata_o(d_rdata),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_gnt_o(i_gnt), .i_done_o(i_done),
    .i_rdata_o(i_rdata),
    .cache(cif.master),
    .hold_flag_o(hold_flag), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0;
    cif.c_rhit_i = 0; cif.c_rdata_i = 0;
    cif.c_whit_i = 0;
    tick(); tick();
    chk("rst_c_re", 32'(cif.c_re_o), 0);
    chk("rst_c_we", 32'(cif.c_we_o), 0);
    chk("rst_gnt", {30'd0, d_gnt, i_gnt}, 0);
    chk("rst_done", {30'd0, d_done, i_done}, 0);
    chk("rst_rdata", d_rdata | i_rdata, 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick();

    // fetch alone, hit 3 cycles after grant
    i_req = 1; i_addr = 32'h100;
    #1 chk("f_hold_pre", 32'(hold_flag), 1);
    tick();
    chk("f_gnt", 32'(i_gnt), 1);
    chk("f_c_re", 32'(cif.c_re_o), 1);
    chk("f_raddr", cif.c_raddr_o, 32'h100);
    chk("f_c_we", 32'(cif.c_we_o), 0);
    tick(); tick();
    chk("f_c_re_hold", 32'(cif.c_re_o), 1);
    chk("f_hold_busy", 32'(hold_flag), 1);
    chk("f_no_done", 32'(i_done), 0);
    cif.c_rhit_i = 1; cif.c_rdata_i = 32'h00500093;
    tick();
    chk("f_done", 32'(i_done), 1);
    chk("f_rdata", i_rdata, 32'h00500093);
    chk("f_hold_done", 32'(hold_flag), 0);
    chk("f_c_re_off", 32'(cif.c_re_o), 0);
    chk("f_gnt_off", 32'(i_gnt), 0);
    i_req = 0; cif.c_rhit_i = 0;
    tick();
    chk("f_done_pulse", 32'(i_done), 0);
    chk("f_rdata_hold", i_rdata, 32'h00500093);

    // data write
    d_req = 1; d_we = 1;
    d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick();
    chk("w_gnt", 32'(d_gnt), 1);
    chk("w_c_we", 32'(cif.c_we_o), 1);
    chk("w_waddr", cif.c_waddr_o, 32'h2000);
    chk("w_wdata", cif.c_wdata_o, 32'hDEADBEEF);
    chk("w_c_re", 32'(cif.c_re_o), 0);
    d_addr = 32'h3000; d_wdata = 32'h11111111;
    tick();
    chk("w_waddr_stable", cif.c_waddr_o, 32'h2000);
    chk("w_wdata_stable", cif.c_wdata_o, 32'hDEADBEEF);
    cif.c_whit_i = 1;
    tick();
    chk("w_done", 32'(d_done), 1);
    chk("w_c_we_off", 32'(cif.c_we_o), 0);
    chk("w_err", 32'(err), 0);
    d_req = 0; d_we = 0; cif.c_whit_i = 0;
    tick();
    chk("w_done_pulse", 32'(d_done), 0);

    // data read, minimum latency
    d_req = 1; d_addr = 32'h40;
    tick();
    chk("r_c_re", 32'(cif.c_re_o), 1);
    chk("r_raddr", cif.c_raddr_o, 32'h40);
    cif.c_rhit_i = 1; cif.c_rdata_i = 32'h12345678;
    tick();
    chk("r_done", 32'(d_done), 1);
    chk("r_rdata", d_rdata, 32'h12345678);
    d_req = 0; cif.c_rhit_i = 0;
    tick();
    chk("r_i_rdata_kept", i_rdata, 32'h00500093);

    // contention: D,D,D,D,I,D,D,D,D,I
    d_req = 1; d_addr = 32'h44; i_req = 1;
    i_addr = 32'h104;
    cif.c_rhit_i = 1; cif.c_rdata_i = 32'hCAFE0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("cont_gnt%0d", k),
          {30'd0, d_gnt, i_gnt},
          (k == 4 || k == 9) ? 32'd1 : 32'd2);
      tick();
      tick();
    end
    d_req = 0; i_req = 0; cif.c_rhit_i = 0;
    tick();

    // timeout: no hit for 8 busy cycles
    d_req = 1; d_addr = 32'h80;
    tick();
    chk("t_gnt", 32'(d_gnt), 1);
    for (int k = 0; k < 7; k++) tick();
    chk("t_no_done", 32'(d_done), 0);
    chk("t_no_err", 32'(err), 0);
    chk("t_c_re_busy", 32'(cif.c_re_o), 1);
    tick();
    chk("t_done", 32'(d_done), 1);
    chk("t_err", 32'(err), 1);
    chk("t_rdata0", d_rdata, 0);
    d_req = 0;
    tick();
    chk("t_err_pulse", 32'(err), 0);
    chk("t_idle", {30'd0, d_gnt, cif.c_re_o}, 0);

    // hit on the same cycle the timeout is reached
    d_req = 1; d_addr = 32'h84;
    tick();
    chk("h_gnt", 32'(d_gnt), 1);
    for (int k = 0; k < 7; k++) tick();
    cif.c_rhit_i = 1; cif.c_rdata_i = 32'hA5A5A5A5;
    tick();
    chk("h_done", 32'(d_done), 1);
    chk("h_err", 32'(err), 0);
    chk("h_rdata", d_rdata, 32'hA5A5A5A5);
    d_req = 0; cif.c_rhit_i = 0;
    tick();

    // async reset in BUSY_I
    i_req = 1; i_addr = 32'h200;
    tick();
    tick();
    chk("x_gnt", 32'(i_gnt), 1);
    #3 rst = 1'b0;
    #1;
    chk("x_c_re", 32'(cif.c_re_o), 0);
    chk("x_i_gnt", 32'(i_gnt), 0);
    chk("x_hold", 32'(hold_flag), 0);
    tick();
    chk("x_no_done", 32'(i_done), 0);
    rst = 1'b1;
    tick();
    chk("x_regnt", 32'(i_gnt), 1);
    chk("x_raddr", cif.c_raddr_o, 32'h200);
    cif.c_rhit_i = 1; cif.c_rdata_i = 32'h00A00113;
    tick();
    chk("x_done", 32'(i_done), 1);
    chk("x_rdata", i_rdata, 32'h00A00113);
    i_req = 0; cif.c_rhit_i = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single read/write port of the L1 cache between the instruction-fetch path (pc_reg side) and the execute-stage load/store path. It grants one requester at a time, latches its command, and holds it stable on the cache port until a hit arrives. It then returns the data with a one-cycle done pulse and stalls the pipeline while fetch is blocked. Data has priority, bounded by an anti-starvation counter, and a watchdog recovers from a cache that never hits.

Parameters:
ADDR_W, 32, address width (matches SramAddrBus)
DATA_W, 32, data width (matches SramBus)
MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits (1..15)
TIMEOUT, 255, cycles in BUSY without hit before abort (1..255, 8-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
d_req_i  in  1  data request; held until d_done_o
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_gnt_o  out  1  data owns port (BUSY_D)
d_done_o  out  1  one-cycle completion pulse
d_rdata_o  out  DATA_W  read data, valid with d_done_o
i_req_i  in  1  fetch request (read only); held until i_done_o
i_addr_i  in  ADDR_W  fetch address (pc)
i_gnt_o  out  1  fetch owns port (BUSY_I)
i_done_o  out  1  one-cycle completion pulse
i_rdata_o  out  DATA_W  instruction, valid with i_done_o
c_re_o  out  1  cache read enable
c_raddr_o  out  ADDR_W  cache read address
c_rhit_i  in  1  cache read hit
c_rdata_i  in  DATA_W  cache read data
c_we_o  out  1  cache write enable
c_waddr_o  out  ADDR_W  cache write address
c_wdata_o  out  DATA_W  cache write data
c_whit_i  in  1  cache write hit
hold_flag_o  out  1  pipeline stall: i_req_i high and fetch not completing this cycle
err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; burst and timeout counters 0.
- FSM states: IDLE, BUSY_D, BUSY_I, DONE. All transitions on the rising edge of clk.
- IDLE: arbitrate on the current requests.
  - Only d_req_i high -> BUSY_D. Only i_req_i high -> BUSY_I.
  - Both high: BUSY_D if burst_cnt < MAX_DATA_BURST, otherwise BUSY_I.
  - On entry to BUSY_x, latch addr/we/wdata into command registers. Requester inputs are ignored after the grant.
- BUSY_D, write: c_we_o=1 with latched waddr/wdata; c_re_o=0. Completes on c_whit_i.
- BUSY_D, read: c_re_o=1 with latched raddr. Completes on c_rhit_i; register c_rdata_i into d_rdata_o.
- BUSY_I: c_re_o=1 with latched i address. Completes on c_rhit_i; register data into i_rdata_o.
- Cache command outputs are registered and stable for the whole BUSY state. They are 0 in IDLE and DONE.
- Completion -> DONE. In DONE, the owner's done_o=1 for exactly one cycle, then -> IDLE.
- Minimum latency: request seen at edge N, cache command valid N+1, hit at N+1, done_o high N+2, next grant N+3.
- Burst counter:
  - Increments on each data grant made while i_req_i is high, saturating at MAX_DATA_BURST.
  - Clears on any fetch grant, or when i_req_i is low at a data grant.
- Timeout:
  - Counter clears on BUSY entry and increments each BUSY cycle without completion.
  - When it reaches TIMEOUT -> DONE with done_o=1, rdata_o=0, err_o=1 (same cycle as done_o).
  - A hit in the same cycle the timeout is reached wins: normal completion, no error.
- hold_flag_o is combinational: i_req_i & ~(state==DONE & owner==I).
- d_rdata_o and i_rdata_o hold their last value between done pulses.
- Reset asserted mid-BUSY: abort immediately and drop the cache command. No done pulse is issued; requesters re-request after reset.
- Requester dropping req while granted: the transaction completes anyway and the done pulse is still issued.

Decomposition:
- Shared defines: reuse the existing defines.v entries (SramAddrBus, SramBus, ReadEnable/ReadDisable, HoldEnable).
- Add to defines.v: ARB_IDLE/ARB_BUSY_D/ARB_BUSY_I/ARB_DONE 2-bit state encodings and ARB_OWNER_D/ARB_OWNER_I.
- One natural sub-module, arb_watchdog: the timeout counter with clear/enable inputs and an expired output.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Fetch alone: i_addr=0x100, c_rhit 3 cycles after grant, c_rdata=0x00500093 -> i_done one cycle with i_rdata=0x00500093; hold_flag high until that cycle.
- Data write: d_we=1, addr=0x2000, wdata=0xDEADBEEF -> c_we_o=1 with c_waddr=0x2000, c_wdata=0xDEADBEEF stable until c_whit; d_done one pulse; c_re_o stays 0.
- Contention with MAX_DATA_BURST=4, d_req and i_req both held high -> grant order D,D,D,D,I,D,D,D,D,I.
- Timeout with TIMEOUT=8, hit never asserted -> err_o and d_done together after 8 BUSY cycles; d_rdata=0; state returns to IDLE.
- Hit and timeout in the same cycle -> normal done with returned data, err_o stays 0.
- rst driven low mid-BUSY_I (asynchronously, between edges) -> c_re_o, i_gnt_o, hold_flag_o drop to 0 immediately; no i_done; after release a new fetch completes normally.
